// File: rtl/ddr_rw_sched.sv
// ddr_rw_sched: single-outstanding DDR burst scheduler arbitrating between
// an AXI write master and an AXI read master. Each side walks its own
// address region burst by burst and wraps back to the region start when the
// next burst would not fit. Round-robin arbitration when both sides ask.
// Optional watchdog on the WAIT states: define SCHED_TIMEOUT_EN.
module ddr_rw_sched #(
  parameter int AW          = 30,
  parameter int LW          = 8,
  parameter int BEAT_BYTES  = 8,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] wr_beg_addr,
  input  logic [AW-1:0] wr_end_addr,
  input  logic [LW-1:0] wr_burst_len,
  input  logic [AW-1:0] rd_beg_addr,
  input  logic [AW-1:0] rd_end_addr,
  input  logic [LW-1:0] rd_burst_len,
  input  logic          wr_req,
  input  logic          rd_req,
  output logic          wr_start,
  output logic          rd_start,
  output logic [AW-1:0] wr_addr,
  output logic [AW-1:0] rd_addr,
  output logic [LW-1:0] wr_len,
  output logic [LW-1:0] rd_len,
  input  logic          wr_done,
  input  logic          rd_done,
  output logic          busy,
  output logic          err
);

  typedef enum logic [2:0] {IDLE, WR_ISSUE, WR_WAIT, RD_ISSUE, RD_WAIT} state_e;

  state_e        state_q, state_d;
  logic          init_q;            // low until the first edge after reset
  logic [AW-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
  logic [LW-1:0] wr_len_q, wr_len_d, rd_len_q, rd_len_d;
  logic          rr_q, rr_d;        // 1: read was granted last
  logic          tmo;

  // Address after a completed burst; arithmetic one bit wider than AW so a
  // region ending at the top of the address space cannot overflow silently.
  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] addr,
                                              input logic [LW-1:0] len,
                                              input logic [AW-1:0] beg,
                                              input logic [AW-1:0] lim);
    logic [AW:0] step;
    logic [AW:0] nxt;
    step = ((AW+1)'(len) + (AW+1)'(1)) * (AW+1)'(BEAT_BYTES);
    nxt  = {1'b0, addr} + step;
    if (nxt + step - (AW+1)'(1) > {1'b0, lim}) return beg;
    return nxt[AW-1:0];
  endfunction

  // Until the first clock after reset the region start is shown directly,
  // so the reset value tracks wr/rd_beg_addr as sampled at release.
  assign wr_addr  = init_q ? wr_addr_q : wr_beg_addr;
  assign rd_addr  = init_q ? rd_addr_q : rd_beg_addr;
  assign wr_len   = wr_len_q;
  assign rd_len   = rd_len_q;
  assign wr_start = (state_q == WR_ISSUE);
  assign rd_start = (state_q == RD_ISSUE);
  assign busy     = (state_q != IDLE);

`ifdef SCHED_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT_CYC + 1);
  logic [WDW-1:0] wd_q, wd_d;
  logic           err_q, err_d;

  assign tmo = (wd_q == WDW'(TIMEOUT_CYC - 1));
  assign err = err_q;

  // Watchdog counts WAIT cycles; cleared whenever the FSM leaves WAIT.
  always_comb begin
    wd_d  = '0;
    err_d = 1'b0;
    if ((state_q == WR_WAIT && !wr_done) || (state_q == RD_WAIT && !rd_done)) begin
      if (tmo) err_d = 1'b1;
      else     wd_d  = wd_q + WDW'(1);
    end
  end

  // Watchdog registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = ^TIMEOUT_CYC;
  assign tmo = 1'b0;
  assign err = 1'b0;
`endif

  // Next-state, arbitration and address/length update.
  always_comb begin
    state_d   = state_q;
    wr_addr_d = wr_addr;
    rd_addr_d = rd_addr;
    wr_len_d  = wr_len_q;
    rd_len_d  = rd_len_q;
    rr_d      = rr_q;
    case (state_q)
      IDLE: begin
        if (wr_req && (!rd_req || rr_q)) begin
          state_d  = WR_ISSUE;
          wr_len_d = wr_burst_len;
          rr_d     = 1'b0;
        end else if (rd_req) begin
          state_d  = RD_ISSUE;
          rd_len_d = rd_burst_len;
          rr_d     = 1'b1;
        end
      end
      WR_ISSUE: state_d = WR_WAIT;
      RD_ISSUE: state_d = RD_WAIT;
      WR_WAIT: begin
        if (wr_done) begin
          state_d   = IDLE;
          wr_addr_d = next_addr(wr_addr, wr_len_q, wr_beg_addr, wr_end_addr);
        end else if (tmo) begin
          state_d   = IDLE;
        end
      end
      RD_WAIT: begin
        if (rd_done) begin
          state_d   = IDLE;
          rd_addr_d = next_addr(rd_addr, rd_len_q, rd_beg_addr, rd_end_addr);
        end else if (tmo) begin
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      init_q    <= 1'b0;
      wr_addr_q <= '0;
      rd_addr_q <= '0;
      wr_len_q  <= '0;
      rd_len_q  <= '0;
      rr_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      init_q    <= 1'b1;
      wr_addr_q <= wr_addr_d;
      rd_addr_q <= rd_addr_d;
      wr_len_q  <= wr_len_d;
      rd_len_q  <= rd_len_d;
      rr_q      <= rr_d;
    end
  end

endmodule

// File: tb/tb_ddr_rw_sched.sv
// tb_ddr_rw_sched: directed vector table plus hand-written sequences for
// alternation, wrap, mid-burst reset and the WAIT watchdog.
module tb_ddr_rw_sched;
  localparam int AW = 30, LW = 8, BB = 8, TMO = 16;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic [AW-1:0] wr_beg_addr, wr_end_addr, rd_beg_addr, rd_end_addr;
  logic [LW-1:0] wr_burst_len, rd_burst_len;
  logic          wr_req, rd_req, wr_done, rd_done;
  logic          wr_start, rd_start, busy, err;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [LW-1:0] wr_len, rd_len;

  int n_chk = 0, n_fail = 0;

  ddr_rw_sched #(.AW(AW), .LW(LW), .BEAT_BYTES(BB), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_beg_addr(wr_beg_addr), .wr_end_addr(wr_end_addr), .wr_burst_len(wr_burst_len),
    .rd_beg_addr(rd_beg_addr), .rd_end_addr(rd_end_addr), .rd_burst_len(rd_burst_len),
    .wr_req(wr_req), .rd_req(rd_req),
    .wr_start(wr_start), .rd_start(rd_start),
    .wr_addr(wr_addr), .rd_addr(rd_addr), .wr_len(wr_len), .rd_len(rd_len),
    .wr_done(wr_done), .rd_done(rd_done), .busy(busy), .err(err));

  always #5 clk = ~clk;

  typedef struct {
    logic          wq, rq, wd, rd;
    logic          ws, rs, bz;
    logic [AW-1:0] wa, ra;
    logic [LW-1:0] wl, rl;
  } vec_t;
  vec_t tbl [14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
  endtask

  // Bounded wait for the given side's start pulse.
  task automatic wait_start(input bit is_wr, input string nm);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      step();
      if (is_wr ? wr_start : rd_start) ok = 1'b1;
    end
    chk(nm, 32'(ok), 32'd1);
  endtask

  // One complete write burst, checking the granted address.
  task automatic wr_burst(input logic [AW-1:0] exp, input string nm);
    wr_req = 1'b1;
    wait_start(1'b1, {nm, "_start"});
    chk({nm, "_addr"}, 32'(wr_addr), 32'(exp));
    wr_req = 1'b0;
    step();
    wr_done = 1'b1;
    step();
    wr_done = 1'b0;
  endtask

  initial begin
    int ovl, errs, first_err;
    bit exp_wr;
    wr_beg_addr = 0;    wr_end_addr = 8191; wr_burst_len = 3;
    rd_beg_addr = 4096; rd_end_addr = 8191; rd_burst_len = 1;
    wr_req = 0; rd_req = 0; wr_done = 0; rd_done = 0;

    //              wq rq wd rd  ws rs bz  wa  ra    wl rl
    tbl[0]  = '{1, 0, 0, 0,  1, 0, 1,  0, 4096, 3, 0};
    tbl[1]  = '{0, 0, 0, 0,  0, 0, 1,  0, 4096, 3, 0};
    tbl[2]  = '{0, 0, 0, 1,  0, 0, 1,  0, 4096, 3, 0};  // stray rd_done in WR_WAIT
    tbl[3]  = '{0, 0, 1, 0,  0, 0, 0, 32, 4096, 3, 0};
    tbl[4]  = '{0, 0, 0, 1,  0, 0, 0, 32, 4096, 3, 0};  // stray rd_done in IDLE
    tbl[5]  = '{1, 1, 0, 0,  0, 1, 1, 32, 4096, 3, 1};  // write was last -> read
    tbl[6]  = '{1, 1, 0, 0,  0, 0, 1, 32, 4096, 3, 1};
    tbl[7]  = '{1, 1, 0, 1,  0, 0, 0, 32, 4112, 3, 1};
    tbl[8]  = '{1, 1, 0, 0,  1, 0, 1, 32, 4112, 3, 1};
    tbl[9]  = '{1, 1, 0, 0,  0, 0, 1, 32, 4112, 3, 1};
    tbl[10] = '{1, 1, 1, 0,  0, 0, 0, 64, 4112, 3, 1};
    tbl[11] = '{0, 1, 0, 0,  0, 1, 1, 64, 4112, 3, 1};
    tbl[12] = '{0, 0, 1, 0,  0, 0, 1, 64, 4112, 3, 1};  // stray wr_done in RD_WAIT
    tbl[13] = '{0, 0, 0, 1,  0, 0, 0, 64, 4128, 3, 1};

    // Reset state
    step();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_wr_start", 32'(wr_start), 0);
    chk("rst_rd_start", 32'(rd_start), 0);
    chk("rst_wr_addr", 32'(wr_addr), 0);
    chk("rst_rd_addr", 32'(rd_addr), 4096);
    chk("rst_wr_len", 32'(wr_len), 0);
    chk("rst_rd_len", 32'(rd_len), 0);
    chk("rst_err", 32'(err), 0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 14; i++) begin
      wr_req = tbl[i].wq; rd_req = tbl[i].rq; wr_done = tbl[i].wd; rd_done = tbl[i].rd;
      step();
      chk($sformatf("row%0d_wr_start", i), 32'(wr_start), 32'(tbl[i].ws));
      chk($sformatf("row%0d_rd_start", i), 32'(rd_start), 32'(tbl[i].rs));
      chk($sformatf("row%0d_busy", i),     32'(busy),     32'(tbl[i].bz));
      chk($sformatf("row%0d_wr_addr", i),  32'(wr_addr),  32'(tbl[i].wa));
      chk($sformatf("row%0d_rd_addr", i),  32'(rd_addr),  32'(tbl[i].ra));
      chk($sformatf("row%0d_wr_len", i),   32'(wr_len),   32'(tbl[i].wl));
      chk($sformatf("row%0d_rd_len", i),   32'(rd_len),   32'(tbl[i].rl));
    end
    wr_req = 0; rd_req = 0; wr_done = 0; rd_done = 0;

    // Both requests held, done 4 cycles after each start: W,R,W,R
    ovl = 0;
    wr_req = 1; rd_req = 1;
    for (int b = 0; b < 4; b++) begin
      bit got;
      exp_wr = (b % 2 == 0);
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
        step();
        if (wr_start && rd_start) ovl++;
        if (wr_start || rd_start) got = 1'b1;
      end
      chk($sformatf("alt%0d_seen", b), 32'(got), 1);
      chk($sformatf("alt%0d_is_wr", b), 32'(wr_start), 32'(exp_wr));
      for (int i = 0; i < 3; i++) begin
        step();
        if (wr_start && rd_start) ovl++;
      end
      if (exp_wr) wr_done = 1; else rd_done = 1;
      step();
      wr_done = 0; rd_done = 0;
    end
    chk("alt_no_overlap", 32'(ovl), 0);
    chk("alt_wr_addr", 32'(wr_addr), 128);
    chk("alt_rd_addr", 32'(rd_addr), 4160);
    wr_req = 0; rd_req = 0;
    step();

    // Wrap; region start changed mid-run takes effect only at the wrap
    wr_beg_addr = 8128;
    do_reset();
    step();
    wr_burst(8128, "wrap0");
    wr_beg_addr = 0;
    wr_burst(8160, "wrap1");
    wr_burst(0, "wrap2");
    wr_burst(32, "wrap3");

    // Reset while in WR_WAIT at 64
    wr_req = 1;
    wait_start(1'b1, "mid_start");
    chk("mid_addr", 32'(wr_addr), 64);
    wr_req = 0;
    step();
    chk("mid_busy_wait", 32'(busy), 1);
    wr_beg_addr = 256;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_wr_addr", 32'(wr_addr), 256);
    chk("mid_rst_wr_len", 32'(wr_len), 0);
    step(); step();
    rst_n = 1'b1;
    step();
    wr_burst(256, "post_rst");

    // Withheld wr_done
    wr_req = 1;
    wait_start(1'b1, "tmo_start");
    wr_req = 0;
`ifdef SCHED_TIMEOUT_EN
    first_err = 0;
    for (int k = 1; k <= 20 && first_err == 0; k++) begin
      step();
      if (err) first_err = k;
    end
    chk("tmo_err_cycle", 32'(first_err), TMO + 1);
    chk("tmo_idle", 32'(busy), 0);
    step();
    chk("tmo_err_pulse", 32'(err), 0);
    wr_burst(288, "tmo_retry");
`else
    errs = 0;
    first_err = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (err) errs++;
    end
    chk("no_tmo_err", 32'(errs), 0);
    chk("no_tmo_busy", 32'(busy), 1);
    chk("no_tmo_first", 32'(first_err), 0);
    wr_done = 1;
    step();
    wr_done = 0;
    chk("no_tmo_done_idle", 32'(busy), 0);
    chk("no_tmo_addr", 32'(wr_addr), 320);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
